// File: rtl/cr_rbus_master_arb.sv
// Round-robin arbiter and sequencer for the rbus ring head port. One transaction
// is in flight at a time; it completes on ack/err_ack or on a bounded timeout.
module cr_rbus_master_arb #(
    parameter int N_REQ            = 2,
    parameter int N_RBUS_ADDR_BITS = 16,
    parameter int N_RBUS_DATA_BITS = 32,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_REQ-1:0]                  req_valid,
    input  logic [N_REQ-1:0]                  req_write,
    input  logic [N_REQ*N_RBUS_ADDR_BITS-1:0] req_addr,
    input  logic [N_REQ*N_RBUS_DATA_BITS-1:0] req_wdata,
    output logic [N_REQ-1:0]                  req_ready,
    output logic [N_REQ-1:0]                  rsp_valid,
    output logic [N_RBUS_DATA_BITS-1:0]       rsp_rdata,
    output logic                              rsp_err,
    output logic                              rsp_timeout,
    output logic [N_RBUS_ADDR_BITS-1:0]       rbus_addr_o,
    output logic                              rbus_wr_strb_o,
    output logic [N_RBUS_DATA_BITS-1:0]       rbus_wr_data_o,
    output logic                              rbus_rd_strb_o,
    input  logic [N_RBUS_DATA_BITS-1:0]       rbus_rd_data_i,
    input  logic                              rbus_ack_i,
    input  logic                              rbus_err_ack_i,
    output logic                              stray_ack
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);
    localparam logic [PTR_W:0]   N_REQ_W  = (PTR_W+1)'(N_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    state_e                      state_q, state_d;
    logic [PTR_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [PTR_W-1:0]            gnt_q;
    logic                        wr_q;
    logic [N_RBUS_ADDR_BITS-1:0] addr_q;
    logic [N_RBUS_DATA_BITS-1:0] wdata_q;
    logic [N_REQ-1:0]            rsp_valid_q;
    logic [N_RBUS_DATA_BITS-1:0] rsp_rdata_q;
    logic                        rsp_err_q;
    logic                        rsp_timeout_q;
    logic                        stray_q;

    logic                        gnt_found;
    logic [PTR_W-1:0]            gnt_idx;
    logic [PTR_W:0]              scan;
    logic                        grant;
    logic                        cmpl;
    logic                        cmpl_err;
    logic                        cmpl_to;
    logic [N_RBUS_DATA_BITS-1:0] cmpl_rdata;
    logic                        ack_any;

    assign ack_any = rbus_ack_i | rbus_err_ack_i;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (scan >= N_REQ_W) scan = scan - N_REQ_W;
            if (!gnt_found && req_valid[scan[PTR_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        cnt_d          = cnt_q;
        req_ready      = '0;
        grant          = 1'b0;
        cmpl           = 1'b0;
        cmpl_err       = 1'b0;
        cmpl_to        = 1'b0;
        cmpl_rdata     = '0;
        rbus_wr_strb_o = 1'b0;
        rbus_rd_strb_o = 1'b0;
        case (state_q)
            IDLE: begin
                // Grant is combinational, so it must be held off while in reset.
                if (gnt_found && !rst) begin
                    grant              = 1'b1;
                    req_ready[gnt_idx] = 1'b1;
                    rr_ptr_d           = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + PTR_W'(1);
                    state_d            = ISSUE;
                end
            end
            ISSUE: begin
                rbus_wr_strb_o = wr_q;
                rbus_rd_strb_o = !wr_q;
                cnt_d          = '0;
                state_d        = WAIT;
            end
            WAIT: begin
                if (ack_any) begin
                    cmpl       = 1'b1;
                    cmpl_err   = rbus_err_ack_i;
                    cmpl_rdata = wr_q ? '0 : rbus_rd_data_i;
                    state_d    = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cmpl     = 1'b1;
                    cmpl_err = 1'b1;
                    cmpl_to  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q      <= '0;
            cnt_q         <= '0;
            gnt_q         <= '0;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            stray_q       <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            if (grant) begin
                gnt_q   <= gnt_idx;
                wr_q    <= req_write[gnt_idx];
                addr_q  <= req_addr[int'(gnt_idx)*N_RBUS_ADDR_BITS +: N_RBUS_ADDR_BITS];
                wdata_q <= req_wdata[int'(gnt_idx)*N_RBUS_DATA_BITS +: N_RBUS_DATA_BITS];
            end
            rsp_valid_q <= '0;
            if (cmpl) rsp_valid_q[gnt_q] <= 1'b1;
            rsp_rdata_q   <= cmpl_rdata;
            rsp_err_q     <= cmpl_err;
            rsp_timeout_q <= cmpl_to;
            // Acks with nothing outstanding (late, post-timeout, post-reset) only flag.
            if (ack_any && state_q != WAIT) stray_q <= 1'b1;
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_err        = rsp_err_q;
    assign rsp_timeout    = rsp_timeout_q;
    assign rbus_addr_o    = addr_q;
    assign rbus_wr_data_o = wdata_q;
    assign stray_ack      = stray_q;

endmodule

// File: tb/tb_cr_rbus_master_arb.sv
// Directed bench for cr_rbus_master_arb: stimulus pushes expected grants, strobes
// and completions into queues; a negedge monitor pops and compares them.
module tb_cr_rbus_master_arb;
    localparam int NR = 2;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NR-1:0]  req_valid, req_write;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]  req_ready, rsp_valid;
    logic [DW-1:0]  rsp_rdata;
    logic           rsp_err, rsp_timeout;
    logic [AW-1:0]  rbus_addr_o;
    logic           rbus_wr_strb_o, rbus_rd_strb_o;
    logic [DW-1:0]  rbus_wr_data_o;
    logic [DW-1:0]  rbus_rd_data_i = '0;
    logic           rbus_ack_i, rbus_err_ack_i;
    logic           stray_ack;
    logic           ring_ack = 1'b0;
    logic           ring_err = 1'b0;
    logic           inj_ack  = 1'b0;

    assign rbus_ack_i     = ring_ack | inj_ack;
    assign rbus_err_ack_i = ring_err;

    cr_rbus_master_arb #(
        .N_REQ(NR), .N_RBUS_ADDR_BITS(AW), .N_RBUS_DATA_BITS(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .rbus_addr_o(rbus_addr_o), .rbus_wr_strb_o(rbus_wr_strb_o),
        .rbus_wr_data_o(rbus_wr_data_o), .rbus_rd_strb_o(rbus_rd_strb_o),
        .rbus_rd_data_i(rbus_rd_data_i), .rbus_ack_i(rbus_ack_i),
        .rbus_err_ack_i(rbus_err_ack_i), .stray_ack(stray_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int idx; int cyc; } gnt_t;
    typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; int cyc; } stb_t;
    typedef struct { int idx; logic [DW-1:0] rdata; logic err; logic to; int cyc; } rsp_t;

    gnt_t gq[$];
    stb_t sq[$];
    rsp_t rq[$];
    gnt_t g_e;
    stb_t s_e;
    rsp_t r_e;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT grant / strobe / completion must match the next expectation.
    always @(negedge clk) begin
        if (req_ready != '0) begin
            if (gq.size() == 0) chk("unexpected_grant", 64'(req_ready), 64'(0));
            else begin
                g_e = gq.pop_front();
                chk("grant_vec", 64'(req_ready), 64'(1) << g_e.idx);
                chk("grant_cyc", 64'(cyc), 64'(g_e.cyc));
            end
        end
        if (rbus_wr_strb_o || rbus_rd_strb_o) begin
            if (sq.size() == 0) chk("unexpected_strobe", 64'({rbus_wr_strb_o, rbus_rd_strb_o}), 64'(0));
            else begin
                s_e = sq.pop_front();
                chk("strobe_kind", 64'({rbus_wr_strb_o, rbus_rd_strb_o}), 64'({s_e.wr, !s_e.wr}));
                chk("strobe_addr", 64'(rbus_addr_o), 64'(s_e.addr));
                if (s_e.wr) chk("strobe_wdata", 64'(rbus_wr_data_o), 64'(s_e.wdata));
                chk("strobe_cyc", 64'(cyc), 64'(s_e.cyc));
            end
        end
        if (rsp_valid != '0) begin
            if (rq.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
            else begin
                r_e = rq.pop_front();
                chk("rsp_vec", 64'(rsp_valid), 64'(1) << r_e.idx);
                chk("rsp_rdata", 64'(rsp_rdata), 64'(r_e.rdata));
                chk("rsp_err", 64'(rsp_err), 64'(r_e.err));
                chk("rsp_timeout", 64'(rsp_timeout), 64'(r_e.to));
                chk("rsp_cyc", 64'(cyc), 64'(r_e.cyc));
            end
        end
    end

    // Ring model: mode 0 ack, 1 err_ack, 2 both, 3 silent; ack ring_dly cycles after the strobe.
    int             ring_mode = 0;
    int             ring_dly  = 1;
    logic           ring_echo = 1'b1;
    logic [DW-1:0]  ring_data = '0;
    logic [AW-1:0]  ring_addr = '0;

    always begin
        @(negedge clk);
        if ((rbus_wr_strb_o || rbus_rd_strb_o) && ring_mode != 3) begin
            ring_addr = rbus_addr_o;
            repeat (ring_dly) @(posedge clk);
            #1;
            ring_ack       = (ring_mode == 0 || ring_mode == 2);
            ring_err       = (ring_mode != 0);
            rbus_rd_data_i = ring_echo ? {16'hC0DE, ring_addr} : ring_data;
            @(posedge clk);
            #1;
            ring_ack       = 1'b0;
            ring_err       = 1'b0;
            rbus_rd_data_i = '0;
        end
    end

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[i]         = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((gq.size() + sq.size() + rq.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(gq.size() + sq.size() + rq.size()), 64'(0));
        gq.delete(); sq.delete(); rq.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    int c;

    initial begin
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_flags", 64'({req_ready, rsp_valid, rsp_err, rsp_timeout,
                              rbus_wr_strb_o, rbus_rd_strb_o, stray_ack}), 64'(0));
        chk("rst_addr", 64'(rbus_addr_o), 64'(0));
        chk("rst_data", 64'({rsp_rdata, rbus_wr_data_o}), 64'(0));
        @(posedge clk); #1 rst = 1'b0;

        // Single read, ring acks two cycles after the strobe.
        ring_mode = 0; ring_dly = 2; ring_echo = 1'b0; ring_data = 32'hA5A5_1234;
        set_req(0, 1'b0, 16'h0040, 32'h0);
        req_valid = 2'b01; c = cyc;
        gq.push_back(gnt_t'{0, c});
        sq.push_back(stb_t'{1'b0, 16'h0040, 32'h0, c + 1});
        rq.push_back(rsp_t'{0, 32'hA5A5_1234, 1'b0, 1'b0, c + 4});
        @(posedge clk); #1 req_valid = '0;
        wait_drain();

        // Round-robin from reset with a 1-cycle ring: strobes 3 cycles apart.
        @(posedge clk); #1 rst = 1'b1;
        ring_mode = 0; ring_dly = 1; ring_echo = 1'b1;
        set_req(0, 1'b0, 16'h0010, 32'h0);
        set_req(1, 1'b0, 16'h0020, 32'h0);
        req_valid = 2'b11;
        @(posedge clk); #1 rst = 1'b0; c = cyc;
        for (int k = 0; k < 4; k++) begin
            gq.push_back(gnt_t'{k % 2, c + 3*k});
            sq.push_back(stb_t'{1'b0, (k % 2 == 0) ? 16'h0010 : 16'h0020, 32'h0, c + 3*k + 1});
            rq.push_back(rsp_t'{k % 2, (k % 2 == 0) ? 32'hC0DE_0010 : 32'hC0DE_0020, 1'b0, 1'b0, c + 3*k + 3});
        end
        repeat (10) @(posedge clk);
        #1 req_valid = '0;
        wait_drain();

        // Write answered by err_ack, then by ack+err_ack together.
        ring_mode = 1; ring_dly = 2; ring_echo = 1'b1;
        set_req(1, 1'b1, 16'h0100, 32'hDEAD_BEEF);
        req_valid = 2'b10; c = cyc;
        gq.push_back(gnt_t'{1, c});
        sq.push_back(stb_t'{1'b1, 16'h0100, 32'hDEAD_BEEF, c + 1});
        rq.push_back(rsp_t'{1, 32'h0, 1'b1, 1'b0, c + 4});
        @(posedge clk); #1 req_valid = '0;
        wait_drain();

        ring_mode = 2;
        set_req(1, 1'b1, 16'h0104, 32'h1234_5678);
        req_valid = 2'b10; c = cyc;
        gq.push_back(gnt_t'{1, c});
        sq.push_back(stb_t'{1'b1, 16'h0104, 32'h1234_5678, c + 1});
        rq.push_back(rsp_t'{1, 32'h0, 1'b1, 1'b0, c + 4});
        @(posedge clk); #1 req_valid = '0;
        wait_drain();

        // Timeout with a silent ring, then a late ack.
        ring_mode = 3;
        set_req(0, 1'b0, 16'h0200, 32'h0);
        req_valid = 2'b01; c = cyc;
        gq.push_back(gnt_t'{0, c});
        sq.push_back(stb_t'{1'b0, 16'h0200, 32'h0, c + 1});
        rq.push_back(rsp_t'{0, 32'h0, 1'b1, 1'b1, c + 2 + TO});
        @(posedge clk); #1 req_valid = '0;
        wait_drain();
        chk("stray_before_late_ack", 64'(stray_ack), 64'(0));
        inj_ack = 1'b1;
        @(posedge clk); #1 inj_ack = 1'b0;
        @(negedge clk);
        chk("stray_after_timeout", 64'(stray_ack), 64'(1));
        @(posedge clk); #1;
        ring_mode = 0; ring_dly = 1; ring_echo = 1'b1;
        set_req(1, 1'b0, 16'h0300, 32'h0);
        req_valid = 2'b10; c = cyc;
        gq.push_back(gnt_t'{1, c});
        sq.push_back(stb_t'{1'b0, 16'h0300, 32'h0, c + 1});
        rq.push_back(rsp_t'{1, 32'hC0DE_0300, 1'b0, 1'b0, c + 3});
        @(posedge clk); #1 req_valid = '0;
        wait_drain();

        // Reset during WAIT aborts without a completion.
        ring_mode = 3;
        set_req(0, 1'b0, 16'h0400, 32'h5555_AAAA);
        req_valid = 2'b01; c = cyc;
        gq.push_back(gnt_t'{0, c});
        sq.push_back(stb_t'{1'b0, 16'h0400, 32'h0, c + 1});
        @(posedge clk); #1 req_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_flags", 64'({req_ready, rsp_valid, rsp_err, rsp_timeout,
                                 rbus_wr_strb_o, rbus_rd_strb_o, stray_ack}), 64'(0));
        chk("midrst_addr", 64'(rbus_addr_o), 64'(0));
        chk("midrst_wdata", 64'(rbus_wr_data_o), 64'(0));
        chk("midrst_rdata", 64'(rsp_rdata), 64'(0));
        @(posedge clk); #1 inj_ack = 1'b1;
        @(posedge clk); #1 inj_ack = 1'b0;
        @(negedge clk);
        chk("stray_after_reset", 64'(stray_ack), 64'(1));
        @(posedge clk); #1;
        ring_mode = 0; ring_dly = 1; ring_echo = 1'b1;
        set_req(0, 1'b0, 16'h0500, 32'h0);
        set_req(1, 1'b0, 16'h0600, 32'h0);
        req_valid = 2'b11; c = cyc;
        gq.push_back(gnt_t'{0, c});
        gq.push_back(gnt_t'{1, c + 3});
        sq.push_back(stb_t'{1'b0, 16'h0500, 32'h0, c + 1});
        sq.push_back(stb_t'{1'b0, 16'h0600, 32'h0, c + 4});
        rq.push_back(rsp_t'{0, 32'hC0DE_0500, 1'b0, 1'b0, c + 3});
        rq.push_back(rsp_t'{1, 32'hC0DE_0600, 1'b0, 1'b0, c + 6});
        repeat (4) @(posedge clk);
        #1 req_valid = '0;
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cr_rbus_master_arb.md
# cr_rbus_master_arb

Round-robin arbiter and transaction sequencer that shares the single head-of-ring master port of the register bus (rbus) ring between N_REQ requesters, e.g. the host CSR bridge, a boot-time config loader and a debug port. The block issues one rbus read or write at a time onto the ring and waits for the matching ack or err_ack to return from the ring tail. It then returns the completion to the granted requester. A per-transaction timeout guards against addresses no ring node claims.

## Interface
- N_REQ, 2: number of requesters; legal range 2..8.
- N_RBUS_ADDR_BITS, 16: rbus address width.
- N_RBUS_DATA_BITS, 32: rbus data width.
- TIMEOUT_CYCLES, 255: maximum WAIT cycles before the block forces completion; legal range 2..65535.

- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  N_REQ  request pending, one bit per requester; held until accepted.
- req_write  in  N_REQ  1 = write, 0 = read, per requester.
- req_addr  in  N_REQ*N_RBUS_ADDR_BITS  address, requester i occupies slice i.
- req_wdata  in  N_REQ*N_RBUS_DATA_BITS  write data, requester i occupies slice i.
- req_ready  out  N_REQ  one-hot grant/accept pulse.
- rsp_valid  out  N_REQ  one-hot completion pulse to the granted requester.
- rsp_rdata  out  N_RBUS_DATA_BITS  read data; shared by all requesters, valid with rsp_valid.
- rsp_err  out  1  err_ack was returned, or timeout occurred.
- rsp_timeout  out  1  completion was forced by timeout.
- rbus_addr_o  out  N_RBUS_ADDR_BITS  ring address.
- rbus_wr_strb_o  out  1  ring write strobe.
- rbus_wr_data_o  out  N_RBUS_DATA_BITS  ring write data.
- rbus_rd_strb_o  out  1  ring read strobe.
- rbus_rd_data_i  in  N_RBUS_DATA_BITS  ring tail read data.
- rbus_ack_i  in  1  ring tail ack.
- rbus_err_ack_i  in  1  ring tail error ack.
- stray_ack  out  1  sticky flag: ack or err_ack arrived outside WAIT; cleared only by rst.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE:**
  - If any req_valid bit is set, grant the first set bit at or after rr_ptr, scanning upward with wrap.
  - Pulse req_ready[g] and latch g, write, addr and wdata.
  - Set rr_ptr = (g+1) mod N_REQ and go to ISSUE.
- **ISSUE:** for exactly one cycle, drive rbus_addr_o and rbus_wr_data_o, and assert rbus_wr_strb_o (write) or rbus_rd_strb_o (read); then go to WAIT with the timeout counter at 0.
- **WAIT:**
  - On ack or err_ack: register the completion and return to IDLE.
    - rsp_rdata = rbus_rd_data_i for a read, 0 for a write.
    - rsp_err = err_ack.
  - If ack and err_ack are both high in the same cycle, err_ack wins: rsp_err = 1.
  - Otherwise increment the counter. When the counter equals TIMEOUT_CYCLES-1 with no ack, complete with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
- An ack arriving after a timeout, or in IDLE or ISSUE, is ignored for response purposes and sets stray_ack.
- rbus_addr_o and rbus_wr_data_o hold their last value outside ISSUE. Both strobes are 0 outside ISSUE.
- Requesters may drop req_valid before grant; no request is lost or duplicated.
- Only one transaction is outstanding at any time.

## Timing
- **Reset:**
  - All outputs are 0, rr_ptr = 0, FSM = IDLE, stray_ack = 0.
  - rst asserted mid-transaction aborts it, with no rsp_valid. A late ack from that aborted transaction after reset sets stray_ack.
- **Latency:**
  - Grant at cycle t; strobe at t+1; WAIT from t+2.
  - Ack at cycle a ≥ t+2 gives rsp_valid at a+1, and the FSM is in IDLE at a+1.
  - A new grant can occur in that same a+1 cycle, so back-to-back strobes are 3 cycles apart for a 1-cycle ring.
- **Timeout:** with no ack, rsp_valid asserts at t+2+TIMEOUT_CYCLES.
- req_ready and rsp_valid are single-cycle pulses. rsp_rdata, rsp_err and rsp_timeout are meaningful only while rsp_valid is high.
- req_valid/addr/wdata are sampled only in the grant cycle.

## Test plan
- **Single read:** requester 0 reads addr 0x0040; ring returns ack with data 0xA5A5_1234 two cycles after the strobe. Expect rd_strb for 1 cycle with addr 0x0040, then rsp_valid[0] with rdata 0xA5A5_1234 and rsp_err = 0.
- **Round-robin:** both requesters hold req_valid continuously from reset. Expect grants in the order 0,1,0,1. Each rsp_valid targets the granted index, and no rd/wr strobe overlaps an outstanding transaction.
- **Error ack:**
  - Requester 1 writes 0x0100 = 0xDEAD_BEEF. Expect wr_strb with that data.
  - Return err_ack. Expect rsp_valid[1], rsp_err = 1, rsp_timeout = 0, rdata = 0.
  - Repeat with ack and err_ack high together. Expect rsp_err = 1.
- **Timeout:**
  - TIMEOUT_CYCLES = 8, no ack. Expect rsp_valid at grant+10 with rsp_err = 1, rsp_timeout = 1.
  - Then inject an ack. Expect stray_ack = 1, no extra rsp_valid, and the next request served normally.
- **Reset mid-WAIT:**
  - Assert rst during WAIT. Expect all outputs 0 the next cycle.
  - A subsequent ack sets stray_ack only.
  - After reset, with both requesters valid, the first grant goes to requester 0.
- **Minimum turnaround:** a 1-cycle ring with continuous requests gives strobes exactly 3 cycles apart.
